fir_coeff_loader: RTL
=====================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 The module SHALL have parameter NTAPS, default 8, giving the number of taps in the coefficient chain it drives (range 2..64).
REQ-002 The module SHALL have parameter CW, default 8, giving the coefficient width in bits.
REQ-003 iclk  input  1  single clock; all logic is on the rising edge.
REQ-004 irst_n  input  1  asynchronous active-low reset.
REQ-005 i_start  input  1  one-cycle request to begin a coefficient load.
REQ-006 i_abort  input  1  cancels any load in progress.
REQ-007 i_coeff_valid  input  1  upstream coefficient word valid.
REQ-008 i_coeff  input  CW  coefficient word, accepted in order h[0], h[1], ... h[NTAPS-1].
REQ-009 o_coeff_ready  output  1  loader can accept a coefficient word this cycle.
REQ-010 o_h_out  output  CW  serial coefficient into h_in of the first tap of the chain.
REQ-011 o_coeff_load  output  1  chain shift enable; taps capture h_in only while high.
REQ-012 o_busy  output  1  high in any state other than IDLE.
REQ-013 o_done  output  1  one-cycle pulse when the chain holds the new coefficient set.

Function
REQ-014 The FSM SHALL have the states IDLE, FILL, SHIFT and DONE.
REQ-015 IDLE->FILL on i_start; the fill counter is cleared to 0 on that transition.
REQ-016 In FILL, o_coeff_ready SHALL be 1; a word is accepted when i_coeff_valid and o_coeff_ready are both 1 on a clock edge, storing i_coeff in buffer[count] and incrementing count.
REQ-017 o_coeff_ready SHALL be 0 in IDLE, SHIFT and DONE; i_coeff_valid in those states is ignored and has no side effect.
REQ-018 FILL->SHIFT on the edge that accepts word NTAPS-1; that word is not lost.
REQ-019 In SHIFT, for exactly NTAPS consecutive cycles, o_coeff_load=1 and o_h_out=buffer[NTAPS-1-k] in cycle k, so h[NTAPS-1] is emitted first and h[0] last.
REQ-020 o_h_out and o_coeff_load SHALL be registered; the first SHIFT cycle is the cycle after the final accept edge.
REQ-021 SHIFT->DONE after the NTAPS-th shift cycle; DONE lasts one cycle with o_done=1 and o_coeff_load=0, then the FSM returns to IDLE.
REQ-022 Outside SHIFT, o_coeff_load SHALL be 0 and o_h_out SHALL be 0.
REQ-023 i_start SHALL be ignored in FILL, SHIFT and DONE.
REQ-024 i_abort in any state SHALL force IDLE on the next edge: count is cleared, o_coeff_load=0 and o_done=0; a partially shifted chain is left as is.
REQ-025 If i_abort and i_start are high together in IDLE, i_abort wins and the FSM stays in IDLE.
REQ-026 If i_abort and an accept occur on the same edge, i_abort wins and the word is discarded.
REQ-027 Buffer contents SHALL not be cleared by abort and are overwritten by the next FILL.

Reset
REQ-028 While irst_n=0, the FSM SHALL be in IDLE, count=0, and o_coeff_ready, o_h_out, o_coeff_load, o_busy and o_done SHALL all be 0, independent of iclk.
REQ-029 Reset asserted mid-FILL or mid-SHIFT SHALL take effect immediately; after release, the loader waits in IDLE for i_start.

Configuration
REQ-030 With FIR_COEFF_CHECKSUM_EN defined, the module SHALL add output o_checksum (CW+8 bits): the modulo-2^(CW+8) sum of the words accepted since the last i_start, cleared on i_start, abort and reset, and held through SHIFT, DONE and IDLE.
REQ-031 Without FIR_COEFF_CHECKSUM_EN, the o_checksum port and its logic SHALL not exist, and all other behaviour is identical.

Verification
REQ-032 NTAPS=8: i_start, then words 1..8 with valid held high -> 8 accepts on 8 consecutive edges, then o_h_out=8,7,...,1 with o_coeff_load=1 for 8 cycles, then o_done=1 for one cycle, then IDLE (o_busy=0).
REQ-033 Valid high only on alternate cycles during FILL -> 8 accepts over 15 cycles; the SHIFT sequence is identical to REQ-032.
REQ-034 i_abort in the 3rd SHIFT cycle -> o_coeff_load=0 from the next cycle, o_done never pulses, o_busy=0; a new i_start then loads 9..16 correctly.
REQ-035 irst_n=0 after 4 accepts -> all outputs are 0 immediately; after release with no i_start, o_coeff_ready stays 0.
REQ-036 i_start pulsed during SHIFT, and i_coeff_valid high during DONE -> no state change and no accept.
REQ-037 FIR_COEFF_CHECKSUM_EN defined, words 1..8 loaded -> o_checksum=36 from the 8th accept onward; a following i_start clears it to 0.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Buffers NTAPS coefficient words, then shifts them into a FIR tap chain, last tap first.
// Latency: first shift cycle follows the final accept edge; NTAPS shift cycles, then a one-cycle done.
// Backpressure: o_coeff_ready is high only in FILL. FIR_COEFF_CHECKSUM_EN adds o_checksum.
module fir_coeff_loader #(
    parameter int NTAPS = 8,
    parameter int CW    = 8
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_coeff_valid,
    input  logic [CW-1:0] i_coeff,
    output logic          o_coeff_ready,
    output logic [CW-1:0] o_h_out,
    output logic          o_coeff_load,
    output logic          o_busy,
`ifdef FIR_COEFF_CHECKSUM_EN
    output logic [CW+7:0] o_checksum,
`endif
    output logic          o_done
);

    localparam int CNTW = $clog2(NTAPS);
    localparam logic [CNTW-1:0] LAST = CNTW'(NTAPS - 1);

    typedef enum logic [1:0] {IDLE, FILL, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CW-1:0]   h_q, h_d;
    logic            load_q, load_d;
    logic            accept;
    logic [CNTW-1:0] rd_idx;
    logic [CW-1:0]   buf_q [NTAPS];

    // Next word to present: count_q is the index of the shift cycle now on the output.
    assign rd_idx = CNTW'(NTAPS - 2) - count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_d  = 1'b0;
        h_d     = '0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = FILL;
                    count_d = '0;
                end
            end
            FILL: begin
                if (i_coeff_valid) begin
                    accept = 1'b1;
                    if (count_q == LAST) begin
                        // The final word goes straight to the output as well as into the buffer.
                        state_d = SHIFT;
                        count_d = '0;
                        load_d  = 1'b1;
                        h_d     = i_coeff;
                    end else begin
                        count_d = count_q + CNTW'(1);
                    end
                end
            end
            SHIFT: begin
                if (count_q == LAST) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNTW'(1);
                    load_d  = 1'b1;
                    h_d     = buf_q[rd_idx];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_abort) begin
            state_d = IDLE;
            count_d = '0;
            load_d  = 1'b0;
            h_d     = '0;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            h_q     <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            h_q     <= h_d;
            load_q  <= load_d;
        end
    end

    // Buffer storage is never cleared; the next FILL overwrites it.
    always_ff @(posedge iclk) begin
        if (accept) begin
            buf_q[count_q] <= i_coeff;
        end
    end

    assign o_coeff_ready = (state_q == FILL);
    assign o_busy        = (state_q != IDLE);
    assign o_done        = (state_q == DONE);
    assign o_coeff_load  = load_q;
    assign o_h_out       = h_q;

`ifdef FIR_COEFF_CHECKSUM_EN
    logic [CW+7:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (i_abort || (state_q == IDLE && i_start)) begin
            cks_d = '0;
        end else if (accept) begin
            cks_d = cks_q + {8'd0, i_coeff};
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign o_checksum = cks_q;
`endif

endmodule
